// File: rtl/simd_mac_accumulator.sv
// rtl/simd_mac_accumulator.sv - per-lane saturating accumulator for packed SIMD multiplier products
module simd_mac_accumulator #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             nrst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      prod_int8,
    input  logic [7:0]       prod_int4_0,
    input  logic [7:0]       prod_int4_1,
    input  logic [3:0]       prod_int2_0,
    input  logic [3:0]       prod_int2_1,
    input  logic [3:0]       prod_int2_2,
    input  logic [3:0]       prod_int2_3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc0,
    output logic [ACC_W-1:0] acc1,
    output logic [ACC_W-1:0] acc2,
    output logic [ACC_W-1:0] acc3,
    output logic             ovf,
    output logic             busy
);

    localparam logic [1:0] MODE_INT4 = 2'd1;
    localparam logic [1:0] MODE_INT2 = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_inc;
    logic [ACC_W-1:0]   acc_q [4];
    logic [ACC_W-1:0]   acc_d [4];
    logic [ACC_W-1:0]   lane_prod [4];
    logic [3:0]         lane_sat;
    logic               ovf_q;
    logic               beat;

    assign beat    = (state_q == S_ACCUM) && in_valid;
    assign cnt_inc = cnt_q + 1'b1;

    // Route the product fields into lanes for the latched precision; reserved mode behaves as int8
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_prod[i] = '0;
        end
        case (mode_q)
            MODE_INT4: begin
                lane_prod[0] = ACC_W'(prod_int4_0);
                lane_prod[1] = ACC_W'(prod_int4_1);
            end
            MODE_INT2: begin
                lane_prod[0] = ACC_W'(prod_int2_0);
                lane_prod[1] = ACC_W'(prod_int2_1);
                lane_prod[2] = ACC_W'(prod_int2_2);
                lane_prod[3] = ACC_W'(prod_int2_3);
            end
            default: begin
                lane_prod[0] = ACC_W'(prod_int8);
            end
        endcase
    end

    // Per-lane add with one guard bit; a carry out clamps the lane to full scale.
    // Once clamped, any further add carries again, so the lane stays pinned.
    always_comb begin
        logic [ACC_W:0] sum;
        for (int i = 0; i < 4; i++) begin
            sum = {1'b0, acc_q[i]} + {1'b0, lane_prod[i]};
            lane_sat[i] = sum[ACC_W];
            acc_d[i]    = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
        end
    end

    // State register
    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a zero-length run skips straight to presenting empty sums
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (in_valid && (cnt_inc == len_q)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded purely from state, keeping in_valid/out_ready off any output path
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Accumulator datapath: clear and latch configuration on start, add lanes on each accepted beat
    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < 4; i++) begin
                acc_q[i] <= '0;
            end
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
            mode_q <= '0;
            len_q  <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            for (int i = 0; i < 4; i++) begin
                acc_q[i] <= '0;
            end
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
            mode_q <= mode;
            len_q  <= len;
        end else if (beat) begin
            for (int i = 0; i < 4; i++) begin
                acc_q[i] <= acc_d[i];
            end
            ovf_q <= ovf_q | (|lane_sat);
            cnt_q <= cnt_inc;
        end
    end

    assign acc0 = acc_q[0];
    assign acc1 = acc_q[1];
    assign acc2 = acc_q[2];
    assign acc3 = acc_q[3];
    assign ovf  = ovf_q;

endmodule
